// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states,
// default halt/reset constants and the byte-address to word-index helper.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HALT_WAIT,
        HALTED,
        FAULT
    } state_t;

    localparam logic [31:0] HALT_INST = 32'h0000_007F;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// PC sequencer: drives the combinational ROM address, buffers each fetched
// word in a one-entry valid/ready slot, and handles redirect, halt and fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = fetch_pkg::RESET_PC,
    parameter int unsigned IMEM_DEPTH   = 32,
    parameter logic [31:0] HALT_INST    = fetch_pkg::HALT_INST,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    state_t      state;
    logic [31:0] pc;
    logic [3:0]  drain_cnt;

    logic xfer;
    logic slot_free;
    logic redir_bad;
    logic pc_oob;

    assign xfer      = if_valid && if_ready;
    assign slot_free = !if_valid || if_ready;
    assign redir_bad = (redir_pc[1:0] != 2'b00) || (word_idx(redir_pc) >= IMEM_DEPTH);
    assign pc_oob    = word_idx(pc) >= IMEM_DEPTH;

    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == HALT_WAIT);
    assign halted    = (state == HALTED);
    assign fault     = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= 32'h0;
            if_pc     <= 32'h0;
            drain_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH;
                end

                FETCH: begin
                    if (redir_valid) begin
                        if_valid <= 1'b0;
                        if (redir_bad) state <= FAULT;
                        else           pc    <= redir_pc;
                    end else if (pc_oob) begin
                        state    <= FAULT;
                        if_valid <= 1'b0;
                    end else if (slot_free) begin
                        // The halt word is never presented downstream; pc parks on it.
                        if (imem_inst == HALT_INST) begin
                            drain_cnt <= 4'(DRAIN_CYCLES);
                            state     <= HALT_WAIT;
                            if_valid  <= 1'b0;
                        end else begin
                            if_inst  <= imem_inst;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                        end
                    end
                end

                HALT_WAIT: begin
                    if (xfer) if_valid <= 1'b0;
                    // A redirect means the halt was fetched down a wrong path.
                    if (redir_valid) begin
                        if_valid  <= 1'b0;
                        drain_cnt <= 4'd0;
                        if (redir_bad) begin
                            state <= FAULT;
                        end else begin
                            state <= FETCH;
                            pc    <= redir_pc;
                        end
                    end else if (!if_valid) begin
                        drain_cnt <= drain_cnt - 4'd1;
                        if (drain_cnt == 4'd1) state <= HALTED;
                    end
                end

                default: begin
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic compared
// cycle by cycle against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam int          DEPTH = 32;
    localparam logic [31:0] HALT  = 32'h0000_007F;
    localparam int          DRAIN = 3;

    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3, M_FAULT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        busy;
    logic        halted;
    logic        fault;

    fetch_ctrl #(
        .RESET_PC    (32'h0),
        .IMEM_DEPTH  (DEPTH),
        .HALT_INST   (HALT),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_inst  (imem_inst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [DEPTH];
    assign imem_inst = (imem_addr[31:7] == 25'd0) ? rom[imem_addr[6:2]] : 32'hDEAD_BEEF;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    bit          m_v;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = 32'h0;
        m_inst = 32'h0;
        m_ipc  = 32'h0;
        m_v    = 1'b0;
        m_cnt  = 0;
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_step();
        bit          was_v;
        bit          take;
        logic [31:0] w;
        was_v = m_v;
        take  = m_v && if_ready;
        case (m_mode)
            M_IDLE: if (start) m_mode = M_RUN;
            M_RUN: begin
                if (redir_valid) begin
                    m_v = 1'b0;
                    if (legal(redir_pc)) m_pc = redir_pc;
                    else                 m_mode = M_FAULT;
                end else if ((m_pc >> 2) >= 32'(DEPTH)) begin
                    m_mode = M_FAULT;
                    m_v    = 1'b0;
                end else if (!was_v || if_ready) begin
                    w = rom[m_pc[6:2]];
                    if (w == HALT) begin
                        m_v    = 1'b0;
                        m_cnt  = DRAIN;
                        m_mode = M_DRAIN;
                    end else begin
                        m_inst = w;
                        m_ipc  = m_pc;
                        m_v    = 1'b1;
                        m_pc   = m_pc + 32'd4;
                    end
                end
            end
            M_DRAIN: begin
                if (take) m_v = 1'b0;
                if (redir_valid) begin
                    m_v   = 1'b0;
                    m_cnt = 0;
                    if (legal(redir_pc)) begin
                        m_pc   = redir_pc;
                        m_mode = M_RUN;
                    end else begin
                        m_mode = M_FAULT;
                    end
                end else if (!was_v) begin
                    if (m_cnt == 1) m_mode = M_HALT;
                    m_cnt--;
                end
            end
            default: m_v = 1'b0;
        endcase
    endtask

    task automatic check_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_v));
        chk("busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_DRAIN)));
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
        chk("fault", 32'(fault), 32'(m_mode == M_FAULT));
        if (m_v) begin
            chk("if_inst", if_inst, m_inst);
            chk("if_pc", if_pc, m_ipc);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_inst"}, if_inst, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic do_reset();
        start       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        if_ready    = 1'b1;
        rst_n       = 1'b0;
        #1;
        model_reset();
        check_reset("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int          pick;

        rom[0] = 32'h0060_0513;
        rom[1] = 32'h00C0_00EF;
        rom[2] = 32'h00A0_2023;
        rom[3] = HALT;
        rom[4] = 32'hFF81_0113;
        rom[5] = 32'h0011_2223;
        for (int i = 6; i < DEPTH; i++) begin
            w = $urandom;
            if (w == HALT) w = w ^ 32'h1;
            rom[i] = w;
        end

        // Sequential fetch, then halt commit at pc=12
        do_reset();
        begin_run();
        cyc(); chk("seq0_pc", if_pc, 32'd0); chk("seq0_inst", if_inst, 32'h0060_0513);
        cyc(); chk("seq1_pc", if_pc, 32'd4); chk("seq1_inst", if_inst, 32'h00C0_00EF);
        cyc(); chk("seq2_pc", if_pc, 32'd8); chk("seq2_inst", if_inst, 32'h00A0_2023);
        cyc(); chk("hw_busy", 32'(busy), 32'd1); chk("hw_valid", 32'(if_valid), 32'd0);
        cyc(); cyc(); chk("hw_not_yet", 32'(halted), 32'd0);
        cyc(); chk("halt_commit", 32'(halted), 32'd1); chk("halt_busy", 32'(busy), 32'd0);
        start = 1'b1; redir_valid = 1'b1; redir_pc = 32'd16;
        cyc(); cyc();
        start = 1'b0; redir_valid = 1'b0;
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_addr", imem_addr, 32'd12);

        // Redirect while jal at pc=4 is buffered
        do_reset();
        begin_run();
        cyc(); cyc(); chk("rd_pre_pc", if_pc, 32'd4);
        redir_valid = 1'b1; redir_pc = 32'd16;
        cyc(); redir_valid = 1'b0;
        chk("rd_flush", 32'(if_valid), 32'd0);
        cyc(); chk("rd_t0_pc", if_pc, 32'd16); chk("rd_t0_inst", if_inst, 32'hFF81_0113);
        cyc(); chk("rd_t1_pc", if_pc, 32'd20); chk("rd_t1_inst", if_inst, 32'h0011_2223);

        // Halt cancelled by a redirect during the drain window
        do_reset();
        begin_run();
        repeat (4) cyc();
        chk("hc_in_wait", 32'(busy), 32'd1);
        redir_valid = 1'b1; redir_pc = 32'd16;
        cyc(); redir_valid = 1'b0;
        chk("hc_addr", imem_addr, 32'd16);
        cyc(); chk("hc_pc", if_pc, 32'd16); chk("hc_valid", 32'(if_valid), 32'd1);
        repeat (6) begin
            cyc(); chk("hc_no_halt", 32'(halted), 32'd0);
        end

        // Backpressure holds the buffer and the pc
        do_reset();
        begin_run();
        cyc(); cyc();
        if_ready = 1'b0;
        repeat (4) begin
            cyc();
            chk("bp_pc", if_pc, 32'd4);
            chk("bp_inst", if_inst, 32'h00C0_00EF);
            chk("bp_addr", imem_addr, 32'd8);
        end
        if_ready = 1'b1;
        cyc(); chk("bp_release", if_pc, 32'd8);

        // Misaligned redirect faults; fault is sticky
        do_reset();
        begin_run();
        cyc();
        redir_valid = 1'b1; redir_pc = 32'h12;
        cyc(); redir_valid = 1'b0;
        chk("mis_fault", 32'(fault), 32'd1); chk("mis_valid", 32'(if_valid), 32'd0);
        start = 1'b1; redir_valid = 1'b1; redir_pc = 32'd16;
        cyc(); cyc();
        start = 1'b0; redir_valid = 1'b0;
        chk("fault_sticky", 32'(fault), 32'd1);

        // Out-of-range redirect faults
        do_reset();
        begin_run();
        cyc();
        redir_valid = 1'b1; redir_pc = 32'd128;
        cyc(); redir_valid = 1'b0;
        chk("oob_fault", 32'(fault), 32'd1);

        // Asynchronous reset mid-run, away from any clock edge
        do_reset();
        begin_run();
        cyc(); cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                start       = ($urandom_range(0, 9) == 0);
                if_ready    = ($urandom_range(0, 3) != 0);
                redir_valid = ($urandom_range(0, 11) == 0);
                pick        = $urandom_range(0, 9);
                if (pick < 7)       redir_pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
                else if (pick == 7) redir_pc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                else if (pick == 8) redir_pc = 32'($urandom_range(DEPTH, 2 * DEPTH)) << 2;
                else                redir_pc = $urandom;
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
